rv32i_lsu: RTL

RV32I_LSU -- requirements
Module: rv32i_lsu

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/rv32i_lsu_align.sv | 85 ++++++++
 rtl/rv32i_lsu.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the RV32I load/store unit.
//   - funct3 width/sign codes used by loads and stores
//   - lsu_state_t: state encoding of the LSU control FSM
package rv32i_pkg;

    // funct3 codes. Stores only use B/H/W; BU/HU are load-only.
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/rv32i_lsu_align.sv
// rv32i_lsu_align: purely combinational lane logic for the LSU.
//   is_store, funct3, addr_lo -> operation being checked / formatted
//   wdata      -> raw store data (rs2)
//   rdata      -> raw load word from the bus
//   wstrb      -> byte-lane strobes for a store
//   wdata_lane -> store data replicated across the lanes
//   load_data  -> selected and sign/zero-extended load result
//   fault      -> misaligned access or illegal funct3
module rv32i_lsu_align
    import rv32i_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        fault
);

    logic        illegal;
    logic        misalign;
    logic [31:0] rdata_shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can leave it unassigned (no latch).
        illegal    = 1'b0;
        misalign   = 1'b0;
        wstrb      = 4'b0000;
        wdata_lane = 32'h0;
        load_data  = 32'h0;

        if (is_store) begin
            illegal = (funct3 > F3_W);
        end else begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end

        // funct3[1:0] encodes the access size for both loads and stores.
        case (funct3[1:0])
            2'b01:   misalign = addr_lo[0];
            2'b10:   misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase
        fault = illegal || misalign;

        case (funct3)
            F3_B: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_H: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            F3_W: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                wstrb      = 4'b0000;
                wdata_lane = 32'h0;
            end
        endcase

        rdata_shifted = rdata >> {addr_lo, 3'b000};
        byte_v        = rdata_shifted[7:0];
        half_v        = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'h0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'h0, half_v};
            F3_W:    load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RV32I load/store unit between the execute stage, a simple
// valid/ready memory bus and the register-file write port.
//   clk, rst                 -> clock, asynchronous active-high reset
//   req_*                    -> operation from execute (accepted in IDLE)
//   mem_*                    -> word-aligned bus request / load response
//   wb_en, wb_addr, wb_data  -> one-cycle register-file write
//   err                      -> one-cycle pulse on misalign/illegal/timeout
//   busy                     -> FSM is not IDLE
module rv32i_lsu
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err,
    output logic        busy
);

    // The counter only has to hold 0 .. TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       result_q, result_d;

    // The lane logic looks at the incoming request while IDLE (to check
    // alignment at acceptance) and at the latched operation otherwise.
    logic              idle;
    logic              al_store;
    logic [2:0]        al_funct3;
    logic [1:0]        al_addr_lo;
    logic [31:0]       al_wdata;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata_lane;
    logic [31:0]       al_load_data;
    logic              al_fault;

    assign idle       = (state_q == IDLE);
    assign al_store   = idle ? req_is_store    : is_store_q;
    assign al_funct3  = idle ? req_funct3      : funct3_q;
    assign al_addr_lo = idle ? req_addr[1:0]   : addr_q[1:0];
    assign al_wdata   = idle ? req_wdata       : wdata_q;

    rv32i_lsu_align u_align (
        .is_store   (al_store),
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .wdata      (al_wdata),
        .rdata      (mem_rdata),
        .wstrb      (al_wstrb),
        .wdata_lane (al_wdata_lane),
        .load_data  (al_load_data),
        .fault      (al_fault)
    );

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rd_d       = req_rd;
                    // A faulting request never reaches the bus: flag it and
                    // stay in IDLE.
                    if (al_fault) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = is_store_q ? IDLE : WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // Data arriving on the last counted cycle still wins.
                if (mem_rvalid) begin
                    result_d = al_load_data;
                    state_d  = WB;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            result_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
        end
    end

    // Outputs are decoded from the state so they are quiet outside their
    // own phase and at reset.
    always_comb begin
        req_ready = idle;
        busy      = !idle;
        err       = err_q;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'h0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;

        if (state_q == REQ) begin
            mem_valid = 1'b1;
            mem_we    = is_store_q;
            mem_addr  = {addr_q[31:2], 2'b00};
            if (is_store_q) begin
                mem_wstrb = al_wstrb;
                mem_wdata = al_wdata_lane;
            end
        end

        if (state_q == WB) begin
            wb_en   = (rd_q != 5'd0);
            wb_addr = rd_q;
            wb_data = result_q;
        end
    end

endmodule
